// File: rtl/spi_ram_burst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : spi_ram_pkg                                                  |
// | Description : Command encodings and frame-width helper shared by the       |
// |               SPI burst RAM, its bus interface and its testbench.          |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_ram_pkg;

   // Two command bits sit on top of every frame, above the payload.
   localparam logic [1:0] CMD_SET_WR = 2'b00;
   localparam logic [1:0] CMD_WRITE  = 2'b01;
   localparam logic [1:0] CMD_SET_RD = 2'b10;
   localparam logic [1:0] CMD_READ   = 2'b11;

   function automatic int frame_width(input int data_width);
      return data_width + 2;
   endfunction

endpackage : spi_ram_pkg
`default_nettype wire

// File: rtl/spi_ram_burst_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : spi_ram_burst_if                                             |
// | Description : Frame stream from the SPI slave into the RAM block and the   |
// |               read-return handshake back to it.                            |
// | Signals     : din[FRAME_W-1:0] frame {cmd, payload}; rx_valid/rx_ready     |
// |               frame handshake; dout read word; tx_valid/tx_ack read-return |
// |               handshake.                                                   |
// | Modports    : master = SPI slave side, slave = RAM block side.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spi_ram_burst_if #(
   parameter int DATA_WIDTH = 8
);
   import spi_ram_pkg::*;

   localparam int FRAME_W = frame_width(DATA_WIDTH);

   logic [FRAME_W-1:0]    din;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] dout;
   logic                  tx_valid;
   logic                  tx_ack;

   modport master (
      output din, rx_valid, tx_ack,
      input  rx_ready, dout, tx_valid
   );

   modport slave (
      input  din, rx_valid, tx_ack,
      output rx_ready, dout, tx_valid
   );

endinterface : spi_ram_burst_if
`default_nettype wire

// File: rtl/spi_ram_burst_sp_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_ram_sp_mem                                               |
// | Description : Single-port synchronous RAM with a registered read port.     |
// |               The read register only loads on re_i, so rdata_o holds its   |
// |               value between reads.                                         |
// | Ports       : clk, rst (async, active-high, clears rdata_o only);          |
// |               we_i write enable; re_i read enable; addr_i shared address;  |
// |               wdata_i write data; rdata_o registered read data.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_ram_sp_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  we_i,
   input  wire logic                  re_i,
   input  wire logic [ADDR_WIDTH-1:0] addr_i,
   input  wire logic [DATA_WIDTH-1:0] wdata_i,
   output logic      [DATA_WIDTH-1:0] rdata_o
);

   localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

   // Storage is intentionally not reset; contents are undefined until written.
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : spi_ram_sp_mem
`default_nettype wire

// File: rtl/spi_ram_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_ram_burst                                                |
// | Description : Command-decoding RAM behind an SPI slave frame stream, with  |
// |               optional address post-increment for bursts and a             |
// |               tx_valid/tx_ack read-return handshake that backpressures     |
// |               the frame stream through rx_ready.                           |
// | Ports       : clk - rising-edge clock                                      |
// |               rst - asynchronous active-high reset                         |
// |               bus - spi_ram_burst_if.slave (din, rx_valid, rx_ready,       |
// |                     dout, tx_valid, tx_ack)                                |
// | Parameters  : DATA_WIDTH word width, ADDR_WIDTH (<= DATA_WIDTH) address    |
// |               width, AUTO_INC nonzero enables address post-increment.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int AUTO_INC   = 1
) (
   input wire logic     clk,
   input wire logic     rst,
   spi_ram_burst_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  tx_valid_q, tx_valid_d;

   logic                  w_rx_ready;
   logic                  w_accept;
   logic [1:0]            w_cmd;
   logic [DATA_WIDTH-1:0] w_payload;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_rdata;

   // A pending read word blocks every command unless it is being acked now,
   // which lets a burst of READs stream one word per cycle.
   assign w_rx_ready = !tx_valid_q || bus.tx_ack;
   assign w_accept   = bus.rx_valid && w_rx_ready;
   assign w_cmd      = bus.din[DATA_WIDTH+1:DATA_WIDTH];
   assign w_payload  = bus.din[DATA_WIDTH-1:0];

   assign w_mem_we   = w_accept && (w_cmd == CMD_WRITE);
   assign w_mem_re   = w_accept && (w_cmd == CMD_READ);
   // One frame per cycle means read and write never collide on the port.
   assign w_mem_addr = w_mem_we ? wr_addr_q : rd_addr_q;

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      tx_valid_d = tx_valid_q;

      // An ack with nothing pending is harmless: tx_valid is already low.
      if (bus.tx_ack) begin
         tx_valid_d = 1'b0;
      end

      if (w_accept) begin
         case (w_cmd)
            CMD_SET_WR: wr_addr_d = w_payload[ADDR_WIDTH-1:0];
            CMD_WRITE: begin
               // Natural ADDR_WIDTH overflow gives the wrap to address 0.
               if (AUTO_INC != 0) begin
                  wr_addr_d = wr_addr_q + ADDR_ONE;
               end
            end
            CMD_SET_RD: rd_addr_d = w_payload[ADDR_WIDTH-1:0];
            CMD_READ: begin
               // A new read overrides a same-edge ack so tx_valid stays high.
               tx_valid_d = 1'b1;
               if (AUTO_INC != 0) begin
                  rd_addr_d = rd_addr_q + ADDR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   spi_ram_sp_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (w_mem_we),
      .re_i    (w_mem_re),
      .addr_i  (w_mem_addr),
      .wdata_i (w_payload),
      .rdata_o (w_rdata)
   );

   assign bus.rx_ready = w_rx_ready;
   assign bus.dout     = w_rdata;
   assign bus.tx_valid = tx_valid_q;

endmodule : spi_ram_burst
`default_nettype wire

// File: tb/tb_spi_ram_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_ram_burst                                             |
// | Description : Directed self-checking bench. Three instances: A (8/8, auto- |
// |               increment), B (8/8, fixed address), C (16/4, auto-inc).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_ram_burst;
   import spi_ram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   spi_ram_burst_if #(.DATA_WIDTH(8))  if_a ();
   spi_ram_burst_if #(.DATA_WIDTH(8))  if_b ();
   spi_ram_burst_if #(.DATA_WIDTH(16)) if_c ();

   spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(0))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   spi_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_INC(1))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));

   // Each frame task presents one frame for one edge and returns #1 after it.
   task automatic fa(input logic [1:0] c, input logic [7:0] p);
      if_a.din = {c, p}; if_a.rx_valid = 1'b1;
      @(posedge clk); #1;
      if_a.rx_valid = 1'b0;
   endtask

   task automatic fb(input logic [1:0] c, input logic [7:0] p);
      if_b.din = {c, p}; if_b.rx_valid = 1'b1;
      @(posedge clk); #1;
      if_b.rx_valid = 1'b0;
   endtask

   task automatic fc(input logic [1:0] c, input logic [15:0] p);
      if_c.din = {c, p}; if_c.rx_valid = 1'b1;
      @(posedge clk); #1;
      if_c.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (if_a.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", if_a.tx_valid); end
      n_tests++; if (if_a.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", if_a.dout); end
      n_tests++; if (if_a.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", if_a.rx_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      if_a.tx_ack = 1'b0;
      fa(CMD_SET_WR, 8'h10); fa(CMD_WRITE, 8'hA5); fa(CMD_SET_RD, 8'h10); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tx_valid: got %b want 1", if_a.tx_valid); end
      n_tests++; if (if_a.dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", if_a.dout); end
      n_tests++; if (if_a.rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rx_ready_stall: got %b want 0", if_a.rx_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (if_a.tx_valid !== 1'b1 || if_a.dout !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got tv=%b dout=%h want tv=1 dout=a5", if_a.tx_valid, if_a.dout); end
      if_a.tx_ack = 1'b1;
      #1;
      n_tests++; if (if_a.rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ack_ready: got %b want 1", if_a.rx_ready); end
      @(posedge clk); #1;
      n_tests++; if (if_a.tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_clear: got %b want 0", if_a.tx_valid); end
      @(posedge clk); #1;
      n_tests++; if (if_a.tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_ack: got %b want 0", if_a.tx_valid); end
      // WRITE immediately followed by READ of the same address
      if_a.tx_ack = 1'b0;
      fa(CMD_SET_WR, 8'h40); fa(CMD_SET_RD, 8'h40); fa(CMD_WRITE, 8'hC3); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'hC3) begin n_fail++; $display("FAIL wr_then_rd: got %h want c3", if_a.dout); end
      if_a.tx_ack = 1'b1;
      @(posedge clk); #1;
      if_a.tx_ack = 1'b0;
   endtask

   task automatic test_burst_wrap();
      fa(CMD_SET_WR, 8'hFE); fa(CMD_WRITE, 8'h11); fa(CMD_WRITE, 8'h22); fa(CMD_WRITE, 8'h33);
      fa(CMD_SET_RD, 8'hFE);
      if_a.tx_ack = 1'b1;
      if_a.din = {CMD_READ, 8'h00}; if_a.rx_valid = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (if_a.dout !== 8'h11 || if_a.tx_valid !== 1'b1) begin n_fail++; $display("FAIL burst_0: got dout=%h tv=%b want 11/1", if_a.dout, if_a.tx_valid); end
      @(posedge clk); #1;
      n_tests++; if (if_a.dout !== 8'h22 || if_a.tx_valid !== 1'b1) begin n_fail++; $display("FAIL burst_1: got dout=%h tv=%b want 22/1", if_a.dout, if_a.tx_valid); end
      @(posedge clk); #1;
      if_a.rx_valid = 1'b0;
      n_tests++; if (if_a.dout !== 8'h33 || if_a.tx_valid !== 1'b1) begin n_fail++; $display("FAIL burst_2_wrap: got dout=%h tv=%b want 33/1", if_a.dout, if_a.tx_valid); end
      @(posedge clk); #1;
      n_tests++; if (if_a.tx_valid !== 1'b0) begin n_fail++; $display("FAIL burst_drain: got %b want 0", if_a.tx_valid); end
      if_a.tx_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      fa(CMD_SET_WR, 8'h20); fa(CMD_WRITE, 8'h99); fa(CMD_WRITE, 8'h5A); fa(CMD_SET_WR, 8'h20);
      fa(CMD_SET_RD, 8'h10); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'hA5) begin n_fail++; $display("FAIL bp_read: got %h want a5", if_a.dout); end
      if_a.din = {CMD_WRITE, 8'h77}; if_a.rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_tests++; if (if_a.rx_ready !== 1'b0 || if_a.dout !== 8'hA5) begin n_fail++; $display("FAIL bp_stall[%0d]: got rdy=%b dout=%h want 0/a5", i, if_a.rx_ready, if_a.dout); end
      end
      if_a.tx_ack = 1'b1;
      #1;
      n_tests++; if (if_a.rx_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", if_a.rx_ready); end
      @(posedge clk); #1;
      if_a.rx_valid = 1'b0;
      n_tests++; if (if_a.tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ack_nonread: got %b want 0", if_a.tx_valid); end
      fa(CMD_SET_RD, 8'h20); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'h77) begin n_fail++; $display("FAIL bp_write_once_a: got %h want 77", if_a.dout); end
      fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'h5A) begin n_fail++; $display("FAIL bp_write_once_b: got %h want 5a", if_a.dout); end
      @(posedge clk); #1;
      if_a.tx_ack = 1'b0;
   endtask

   task automatic test_async_reset();
      fa(CMD_SET_RD, 8'hFF); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'h22 || if_a.tx_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got dout=%h tv=%b want 22/1", if_a.dout, if_a.tx_valid); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (if_a.tx_valid !== 1'b0 || if_a.dout !== 8'h00) begin n_fail++; $display("FAIL ar_immediate: got tv=%b dout=%h want 0/00", if_a.tx_valid, if_a.dout); end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'h33) begin n_fail++; $display("FAIL ar_rd_addr0: got %h want 33", if_a.dout); end
      if_a.tx_ack = 1'b1;
      fa(CMD_WRITE, 8'hE1);
      if_a.tx_ack = 1'b0;
      fa(CMD_SET_RD, 8'h00); fa(CMD_READ, 8'h00);
      n_tests++; if (if_a.dout !== 8'hE1) begin n_fail++; $display("FAIL ar_wr_addr0: got %h want e1", if_a.dout); end
      if_a.tx_ack = 1'b1;
      @(posedge clk); #1;
      if_a.tx_ack = 1'b0;
   endtask

   task automatic test_no_inc();
      if_b.tx_ack = 1'b1;
      fb(CMD_SET_WR, 8'h06); fb(CMD_WRITE, 8'h66);
      fb(CMD_SET_WR, 8'h05); fb(CMD_WRITE, 8'h01); fb(CMD_WRITE, 8'h02);
      fb(CMD_SET_RD, 8'h05); fb(CMD_READ, 8'h00);
      n_tests++; if (if_b.dout !== 8'h02) begin n_fail++; $display("FAIL noinc_rd0: got %h want 02", if_b.dout); end
      fb(CMD_READ, 8'h00);
      n_tests++; if (if_b.dout !== 8'h02 || if_b.tx_valid !== 1'b1) begin n_fail++; $display("FAIL noinc_rd1: got dout=%h tv=%b want 02/1", if_b.dout, if_b.tx_valid); end
      fb(CMD_SET_RD, 8'h06); fb(CMD_READ, 8'h00);
      n_tests++; if (if_b.dout !== 8'h66) begin n_fail++; $display("FAIL noinc_neighbour: got %h want 66", if_b.dout); end
   endtask

   task automatic test_wide();
      if_c.tx_ack = 1'b1;
      fc(CMD_SET_WR, 16'hFFF3); fc(CMD_WRITE, 16'hBEEF);
      fc(CMD_SET_RD, 16'h0013); fc(CMD_READ, 16'h0000);
      n_tests++; if (if_c.dout !== 16'hBEEF) begin n_fail++; $display("FAIL wide_upper_ignored: got %h want beef", if_c.dout); end
      fc(CMD_SET_WR, 16'h000F); fc(CMD_WRITE, 16'h1234); fc(CMD_WRITE, 16'h5678);
      fc(CMD_SET_RD, 16'h0000); fc(CMD_READ, 16'h0000);
      n_tests++; if (if_c.dout !== 16'h5678) begin n_fail++; $display("FAIL wide_wrap: got %h want 5678", if_c.dout); end
      fc(CMD_SET_RD, 16'h000F); fc(CMD_READ, 16'h0000);
      n_tests++; if (if_c.dout !== 16'h1234) begin n_fail++; $display("FAIL wide_top: got %h want 1234", if_c.dout); end
   endtask

   initial begin
      if_a.din = '0; if_a.rx_valid = 1'b0; if_a.tx_ack = 1'b0;
      if_b.din = '0; if_b.rx_valid = 1'b0; if_b.tx_ack = 1'b0;
      if_c.din = '0; if_c.rx_valid = 1'b0; if_c.tx_ack = 1'b0;
      test_reset();
      test_basic();
      test_burst_wrap();
      test_backpressure();
      test_async_reset();
      test_no_inc();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule : tb_spi_ram_burst
`default_nettype wire
